// File: rtl/uart_tx_sched.sv
// Arbitrates one UART transmitter between a CPU store FIFO and a debug byte source.
// The UART core has no ready signal, so writes are paced to one frame every BYTE_CYCLES clocks.
module uart_tx_sched #(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = 8681,
  parameter int CPU_BURST   = 4
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     cpu_we,
  input  logic [7:0]               cpu_data,
  output logic                     cpu_full,
  output logic                     ovf,
  input  logic                     dbg_valid,
  input  logic [7:0]               dbg_data,
  output logic                     dbg_ready,
  output logic                     uart_wr,
  output logic [7:0]               uart_dat,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BYTE_CYCLES);
  localparam int RW = $clog2(CPU_BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [CW-1:0] wcnt;
  logic [RW-1:0] run;

  logic empty, push, in_idle, grant_cpu, grant_dbg;

  assign empty     = (count == '0);
  assign cpu_full  = (count == (AW+1)'(DEPTH));
  assign push      = cpu_we & ~cpu_full;
  assign in_idle   = (state == S_IDLE);
  // CPU keeps priority until it has used its burst allowance against a waiting debug byte
  assign grant_cpu = in_idle & ~empty & ((run < RW'(CPU_BURST)) | ~dbg_valid);
  assign grant_dbg = in_idle & ~grant_cpu & dbg_valid;

  assign dbg_ready  = grant_dbg;
  assign uart_wr    = (state == S_ISSUE);
  assign fifo_count = count;
  assign idle       = in_idle & empty & ~dbg_valid;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= cpu_data;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push)      wptr <= wptr + 1'b1;
      if (grant_cpu) rptr <= rptr + 1'b1;
      case ({push, grant_cpu})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (cpu_we && cpu_full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      uart_dat <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_cpu) begin
            uart_dat <= mem[rptr];
            state    <= S_ISSUE;
          end else if (grant_dbg) begin
            uart_dat <= dbg_data;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ISSUE + WAIT + IDLE grant cycle add up to exactly BYTE_CYCLES
          wcnt  <= CW'(BYTE_CYCLES - 3);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_IDLE;
          else            wcnt  <= wcnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      run <= '0;
    end else if (in_idle) begin
      if (grant_dbg || !dbg_valid)                    run <= '0;
      else if (grant_cpu && run < RW'(CPU_BURST))     run <= run + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with BYTE_CYCLES=8; inputs and checks on the falling edge.
module tb_uart_tx_sched;
  localparam int B = 8;

  logic       CLK = 1'b0, NRST = 1'b0;
  logic       cpu_we = 1'b0, dbg_valid = 1'b0;
  logic [7:0] cpu_data = 8'h00, dbg_data = 8'h00;
  logic       cpu_full, ovf, dbg_ready, uart_wr, idle;
  logic [7:0] uart_dat;
  logic [4:0] fifo_count;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] mon_q[$];
  int         mon_t[$];

  uart_tx_sched #(.DEPTH(16), .BYTE_CYCLES(B), .CPU_BURST(4)) dut (
    .CLK(CLK), .NRST(NRST), .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_full(cpu_full),
    .ovf(ovf), .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .uart_wr(uart_wr), .uart_dat(uart_dat), .fifo_count(fifo_count), .idle(idle)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (NRST && uart_wr) begin
    mon_q.push_back(uart_dat);
    mon_t.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && !idle; i++) @(negedge CLK);
    chk(tag, idle, 1);
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && mon_q.size() < n; i++) begin
      @(negedge CLK); #1;
    end
    chk(tag, mon_q.size(), n);
  endtask

  logic [7:0] exp3 [11];
  int rdy_n;
  logic rdy_prev;

  initial begin
    exp3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hD0, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};

    // reset state
    nc(3);
    chk("rst_wr", uart_wr, 0);
    chk("rst_dat", uart_dat, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", cpu_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rdy", dbg_ready, 0);
    chk("rst_idle", idle, 1);
    NRST = 1'b1;
    nc(1);

    // single push: strobe two edges after the push edge
    cpu_we = 1'b1; cpu_data = 8'h41;
    nc(1);
    cpu_we = 1'b0;
    chk("t1_count1", fifo_count, 1);
    chk("t1_wr_pre", uart_wr, 0);
    nc(1);
    chk("t1_wr", uart_wr, 1);
    chk("t1_dat", uart_dat, 8'h41);
    chk("t1_count0", fifo_count, 0);
    nc(1);
    chk("t1_wr_off", uart_wr, 0);
    nc(5);
    chk("t1_busy", idle, 0);
    nc(1);
    chk("t1_idle", idle, 1);

    // fill to full while draining, overflow, full push not rescued by pop
    mon_q.delete(); mon_t.delete();
    for (int k = 0; k < 26; k++) begin
      cpu_we = 1'b1; cpu_data = 8'(8'h20 + k);
      nc(1);
      if (k == 17) begin
        chk("t2_notfull", cpu_full, 0);
        chk("t2_count15", fifo_count, 15);
      end
      if (k == 18) begin
        chk("t2_full", cpu_full, 1);
        chk("t2_count16", fifo_count, 16);
        chk("t2_ovf_pre", ovf, 0);
      end
      if (k == 19) begin
        chk("t2_ovf", ovf, 1);
        chk("t2_count_hold", fifo_count, 16);
      end
    end
    cpu_we = 1'b0;
    chk("t2_pop_no_rescue", fifo_count, 15);
    chk("t2_full_clr", cpu_full, 0);
    chk("t2_ovf_sticky", ovf, 1);
    wait_q("t2_nstrobes", 19, 250);
    nc(20);
    chk("t2_nstrobes_final", mon_q.size(), 19);
    for (int i = 0; i < 19 && i < mon_q.size(); i++) begin
      chk($sformatf("t2_dat%0d", i), mon_q[i], 8'(8'h20 + i));
      if (i > 0) chk($sformatf("t2_gap%0d", i), mon_t[i] - mon_t[i-1], B);
    end
    wait_idle("t2_idle");

    // burst limit: four CPU grants, then the waiting debug byte
    mon_q.delete(); mon_t.delete();
    rdy_n = 0; rdy_prev = 1'b0;
    for (int k = 0; k < 250; k++) begin
      if (dbg_ready) rdy_n++;
      if (rdy_prev) dbg_valid = 1'b0;
      rdy_prev = dbg_ready;
      if (k < 10) begin cpu_we = 1'b1; cpu_data = 8'(8'h10 + k); end
      else cpu_we = 1'b0;
      if (k == 1) begin dbg_valid = 1'b1; dbg_data = 8'hD0; end
      if (k > 10 && mon_q.size() >= 11) break;
      nc(1);
    end
    cpu_we = 1'b0; dbg_valid = 1'b0;
    chk("t3_nstrobes", mon_q.size(), 11);
    chk("t3_rdy_cycles", rdy_n, 1);
    for (int i = 0; i < 11 && i < mon_q.size(); i++)
      chk($sformatf("t3_order%0d", i), mon_q[i], exp3[i]);
    wait_idle("t3_idle");

    // debug with empty FIFO: immediate ready, then paced by BYTE_CYCLES
    nc(1);
    dbg_valid = 1'b1; dbg_data = 8'hD0;
    #1;
    chk("t4_rdy_now", dbg_ready, 1);
    nc(1);
    chk("t4_wr", uart_wr, 1);
    chk("t4_dat", uart_dat, 8'hD0);
    chk("t4_rdy_drop", dbg_ready, 0);
    dbg_data = 8'hD1;
    nc(6);
    chk("t4_rdy_held", dbg_ready, 0);
    nc(1);
    chk("t4_rdy_next", dbg_ready, 1);
    nc(1);
    chk("t4_wr2", uart_wr, 1);
    chk("t4_dat2", uart_dat, 8'hD1);
    dbg_valid = 1'b0;
    wait_idle("t4_idle");

    // reset in WAIT with queued bytes
    for (int k = 0; k < 6; k++) begin
      cpu_we = 1'b1; cpu_data = 8'(8'h50 + k);
      nc(1);
    end
    cpu_we = 1'b0;
    chk("t5_count5", fifo_count, 5);
    chk("t5_wait", uart_wr, 0);
    chk("t5_busy", idle, 0);
    chk("t5_ovf_pre", ovf, 1);
    NRST = 1'b0;
    #1;
    chk("t5_count", fifo_count, 0);
    chk("t5_full", cpu_full, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_dat", uart_dat, 0);
    chk("t5_wr", uart_wr, 0);
    chk("t5_idle", idle, 1);
    chk("t5_rdy", dbg_ready, 0);
    nc(2);
    NRST = 1'b1;
    mon_q.delete(); mon_t.delete();
    nc(20);
    chk("t5_quiet", mon_q.size(), 0);
    cpu_we = 1'b1; cpu_data = 8'h5A;
    nc(1);
    cpu_we = 1'b0;
    nc(1);
    chk("t5_wr_new", uart_wr, 1);
    chk("t5_dat_new", uart_dat, 8'h5A);
    wait_idle("t5_idle2");

    // push+pop at count 3, then 40 bytes through the wrapping pointers
    mon_q.delete(); mon_t.delete();
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1'b1; cpu_data = 8'(8'h60 + k);
      nc(1);
    end
    cpu_we = 1'b0;
    chk("t6_count3", fifo_count, 3);
    nc(5);
    chk("t6_count3_pre", fifo_count, 3);
    cpu_we = 1'b1; cpu_data = 8'h64;
    nc(1);
    cpu_we = 1'b0;
    chk("t6_pushpop", fifo_count, 3);
    chk("t6_wr", uart_wr, 1);
    chk("t6_dat", uart_dat, 8'h61);
    for (int i = 0; i < 40; i++) begin
      cpu_we = 1'b1; cpu_data = 8'(8'h80 + i);
      nc(1);
      cpu_we = 1'b0;
      nc(5);
    end
    wait_q("t6_nstrobes", 45, 500);
    for (int i = 0; i < 45 && i < mon_q.size(); i++)
      chk($sformatf("t6_dat%0d", i), mon_q[i], (i < 5) ? 8'(8'h60 + i) : 8'(8'h80 + i - 5));
    wait_idle("t6_idle");
    chk("t6_no_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
